regfile_wr_demux: RTL and testbench
===================================

REGFILE_WR_DEMUX -- requirements
Module: regfile_wr_demux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning write-data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning buffer entries (fixed at 2; other values unsupported).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  write request present.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 The block SHALL have port in_addr  input  5  destination register number.
REQ-008 The block SHALL have port in_data  input  DATA_W  write-back data.
REQ-009 The block SHALL have port rf_stall  input  1  register file cannot take a write this cycle.
REQ-010 The block SHALL have port wr_en  output  32  one-hot register write enables.
REQ-011 The block SHALL have port wr_addr  output  5  address of head entry.
REQ-012 The block SHALL have port wr_data  output  DATA_W  data of head entry.
REQ-013 The block SHALL have port zero_drop_cnt  output  8  count of discarded writes to register 0.

Function
REQ-014 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 1 when fewer than 2 entries are buffered and SHALL be a registered function of occupancy only (no path from rf_stall or in_valid).
REQ-016 An accepted request with in_addr = 0 SHALL not be buffered; zero_drop_cnt SHALL increment by 1, saturating at 255.
REQ-017 An accepted request with in_addr != 0 SHALL be appended to a 2-entry FIFO in arrival order.
REQ-018 A commit SHALL occur in every cycle where the FIFO is non-empty and rf_stall = 0; the head entry is popped at that edge.
REQ-019 wr_en SHALL equal 1 << wr_addr during a commit cycle and 0 otherwise; wr_en[0] SHALL never be 1.
REQ-020 wr_addr and wr_data SHALL show the head entry whenever the FIFO is non-empty and SHALL hold the last value when empty.
REQ-021 Latency: a request accepted at edge N into an empty FIFO SHALL assert wr_en in cycle N+1 if rf_stall = 0.
REQ-022 Simultaneous accept and commit with 1 entry buffered SHALL leave occupancy at 1, with the new entry as head next cycle.
REQ-023 Full FIFO with a commit SHALL not accept in that cycle (in_ready already 0); in_ready SHALL rise the following cycle.
REQ-024 Back-to-back requests with rf_stall = 0 SHALL sustain one commit per cycle with in_ready held at 1.
REQ-025 While rf_stall = 1, FIFO contents and outputs SHALL hold; no entry SHALL be lost or duplicated.

Reset
REQ-026 With reset = 1 at a rising edge, occupancy SHALL become 0 and pending entries SHALL be discarded without commit.
REQ-027 After reset: in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0, zero_drop_cnt = 0.
REQ-028 Requests presented in a cycle with reset = 1 SHALL be ignored.

Configuration
REQ-029 Macro WB_FWD_EN, when defined, SHALL add ports rd_addr (input, 5), fwd_hit (output, 1) and fwd_data (output, DATA_W).
REQ-030 With WB_FWD_EN, fwd_hit SHALL be 1 combinationally when rd_addr != 0 and matches a buffered entry; fwd_data SHALL be the newest matching entry's data, else 0.
REQ-031 Without WB_FWD_EN, those ports SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then in_valid with addr 5, data 0xDEADBEEF, rf_stall 0 -> next cycle wr_en = 0x00000020, wr_data = 0xDEADBEEF, then wr_en = 0.
REQ-033 Three requests to addr 0 -> no wr_en pulse, zero_drop_cnt = 3; 300 such requests -> zero_drop_cnt = 255.
REQ-034 rf_stall = 1, push addr 1 then addr 2 -> in_ready = 0 after second; release stall -> wr_en 0x2 then 0x4 in consecutive cycles.
REQ-035 Full FIFO, assert reset for one cycle -> no wr_en pulse, in_ready = 1, outputs at reset values.
REQ-036 WB_FWD_EN: stall, push addr 7 data 0x11 then addr 7 data 0x22, rd_addr = 7 -> fwd_hit = 1, fwd_data = 0x22; rd_addr = 0 -> fwd_hit = 0.

Source files
------------

// File: rtl/regfile_wr_demux.sv
// Register-file write-back buffer: a 2-entry FIFO that drains one write per cycle into one-hot enables.
// Optional WB_FWD_EN adds a read-address forwarding port that snoops the buffered entries.
module regfile_wr_demux #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rf_stall,
    output logic [31:0]       wr_en,
    output logic [4:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        zero_drop_cnt
`ifdef WB_FWD_EN
    ,
    input  logic [4:0]        rd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [4:0]        addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [7:0]        drop_q, drop_d;
    logic              accept;
    logic              commit;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Slot 0 is always the head; it is left untouched when the last entry drains so the
    // write port keeps showing the most recent head.
    always_comb begin
        accept     = in_valid && in_ready_q;
        commit     = (count_q != 2'd0) && !rf_stall && !reset;
        count_d    = count_q;
        addr0_d    = addr0_q;
        addr1_d    = addr1_q;
        data0_d    = data0_q;
        data1_d    = data1_q;
        drop_d     = drop_q;

        if (commit) begin
            if (count_q == 2'd2) begin
                addr0_d = addr1_q;
                data0_d = data1_q;
            end
            count_d = count_q - 2'd1;
        end

        if (accept) begin
            if (in_addr == 5'd0) begin
                drop_d = sat_inc8(drop_q);
            end else begin
                if (count_d == 2'd0) begin
                    addr0_d = in_addr;
                    data0_d = in_data;
                end else begin
                    addr1_d = in_addr;
                    data1_d = in_data;
                end
                count_d = count_d + 2'd1;
            end
        end

        in_ready_d = (count_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
            addr0_q    <= '0;
            addr1_q    <= '0;
            data0_q    <= '0;
            data1_q    <= '0;
            drop_q     <= '0;
        end else begin
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            data0_q    <= data0_d;
            data1_q    <= data1_d;
            drop_q     <= drop_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign wr_addr       = addr0_q;
    assign wr_data       = data0_q;
    assign wr_en         = commit ? (32'd1 << addr0_q) : 32'd0;
    assign zero_drop_cnt = drop_q;

`ifdef WB_FWD_EN
    // Slot 1 is the newer entry, so it takes priority when both match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (rd_addr != 5'd0) begin
            if ((count_q != 2'd0) && (addr0_q == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data0_q;
            end
            if ((count_q == 2'd2) && (addr1_q == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data1_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Scoreboard bench for regfile_wr_demux: directed scenarios then randomized traffic vs a queue model.
module tb_regfile_wr_demux;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_addr = '0;
    logic [DW-1:0] in_data = '0;
    logic          rf_stall = 1'b1;
    logic [31:0]   wr_en;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    zero_drop_cnt;
`ifdef WB_FWD_EN
    logic [4:0]    rd_addr = '0;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    regfile_wr_demux #(.DATA_W(DW), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .rf_stall      (rf_stall),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .zero_drop_cnt (zero_drop_cnt)
`ifdef WB_FWD_EN
        ,
        .rd_addr       (rd_addr),
        .fwd_hit       (fwd_hit),
        .fwd_data      (fwd_data)
`endif
    );

    typedef struct packed {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          exp_q[$];
    int            occ = 0;
    int            zcnt = 0;
    logic [4:0]    last_a = '0;
    logic [DW-1:0] last_d = '0;
    bit            mon_en = 1'b0;
    int            total = 0;
    int            bad = 0;
    logic [31:0]   one = 32'd1;
    bit            mon_ec;
    ent_t          mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // One clock cycle: drive inputs, advance the reference model at the edge, check state outputs.
    task automatic step(input logic v, input logic [4:0] a, input logic [DW-1:0] d,
                        input logic st, input logic r);
        bit            commit_m, acc_m;
`ifdef WB_FWD_EN
        bit            mh;
        logic [DW-1:0] md;
`endif
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        rf_stall = st;
        reset    = r;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            occ    = 0;
            zcnt   = 0;
            last_a = '0;
            last_d = '0;
        end else begin
            commit_m = (occ > 0) && !st;
            acc_m    = v && (occ < 2);
            if (commit_m) occ--;
            if (acc_m) begin
                if (a == 5'd0) begin
                    zcnt = (zcnt + 1 > 255) ? 255 : zcnt + 1;
                end else begin
                    exp_q.push_back('{a: a, d: d});
                    occ++;
                end
            end
            if (exp_q.size() > 0) begin
                last_a = exp_q[0].a;
                last_d = exp_q[0].d;
            end
        end
        #1;
        chk("in_ready", in_ready, (occ < 2));
        chk("zero_drop_cnt", zero_drop_cnt, zcnt);
`ifdef WB_FWD_EN
        mh = 1'b0;
        md = '0;
        if (rd_addr != 5'd0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].a == rd_addr) begin
                    mh = 1'b1;
                    md = exp_q[i].d;
                end
            end
        end
        chk("fwd_hit", fwd_hit, mh);
        chk("fwd_data", fwd_data, md);
`endif
    endtask

    // Monitor: whenever the DUT commits, pop the expected write and compare.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_q.size() > 0) begin
                    chk("head_addr", wr_addr, exp_q[0].a);
                    chk("head_data", wr_data, exp_q[0].d);
                end else begin
                    chk("hold_addr", wr_addr, last_a);
                    chk("hold_data", wr_data, last_d);
                end
                mon_ec = (exp_q.size() > 0) && !rf_stall && !reset;
                chk("commit", (wr_en != 32'd0), mon_ec);
                if (mon_ec) begin
                    mon_e = exp_q.pop_front();
                    chk("wr_en", wr_en, one << mon_e.a);
                    chk("wr_data", wr_data, mon_e.d);
                end
            end
        end
    end

    initial begin
        step(1'b0, 5'd0, '0, 1'b1, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 5'd0, '0, 1'b1, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_wr_en", wr_en, 32'd0);
        chk("rst_wr_addr", wr_addr, 5'd0);
        chk("rst_wr_data", wr_data, '0);
        chk("rst_zero_drop", zero_drop_cnt, 8'd0);

        // Single write to r5, seen the cycle after acceptance.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        chk("lat_wr_en", wr_en, 32'h0000_0020);
        chk("lat_wr_data", wr_data, 32'hDEADBEEF);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
        chk("lat_wr_en_off", wr_en, 32'd0);

        // Writes to r0 are dropped and counted, saturating.
        for (int i = 0; i < 3; i++) step(1'b1, 5'd0, $urandom, 1'b0, 1'b0);
        chk("zero_drop_3", zero_drop_cnt, 8'd3);
        for (int i = 0; i < 300; i++) step(1'b1, 5'd0, $urandom, 1'b0, 1'b0);
        chk("zero_drop_sat", zero_drop_cnt, 8'd255);

        // Fill under stall, then drain in order.
        step(1'b1, 5'd1, 32'h1111, 1'b1, 1'b0);
        step(1'b1, 5'd2, 32'h2222, 1'b1, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        step(1'b1, 5'd3, 32'h3333, 1'b1, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);

        // Back-to-back traffic at full rate.
        for (int i = 0; i < 6; i++) step(1'b1, 5'(i + 8), $urandom, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);

        // Reset with a full FIFO discards everything.
        step(1'b1, 5'd9, 32'hA5A5, 1'b1, 1'b0);
        step(1'b1, 5'd10, 32'h5A5A, 1'b1, 1'b0);
        step(1'b1, 5'd11, 32'hFFFF, 1'b0, 1'b1);
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_wr_addr", wr_addr, 5'd0);
        chk("rst2_wr_data", wr_data, '0);
        chk("rst2_zero_drop", zero_drop_cnt, 8'd0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
        chk("rst2_wr_en", wr_en, 32'd0);

`ifdef WB_FWD_EN
        step(1'b1, 5'd7, 32'h11, 1'b1, 1'b0);
        step(1'b1, 5'd7, 32'h22, 1'b1, 1'b0);
        rd_addr = 5'd7;
        #1;
        chk("fwd7_hit", fwd_hit, 1'b1);
        chk("fwd7_data", fwd_data, 32'h22);
        rd_addr = 5'd0;
        #1;
        chk("fwd0_hit", fwd_hit, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 2000; i++) begin
`ifdef WB_FWD_EN
            rd_addr = 5'($urandom_range(0, 7));
`endif
            step(($urandom % 4) != 0,
                 (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                 $urandom,
                 ($urandom % 3) == 0,
                 ($urandom % 200) == 0);
        end
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
